// File: rtl/dct_frame_scheduler_pkg.sv
// Shared definitions for the DCT frame scheduler: state encoding, block geometry
// and the frame-memory pixel address formula.
package dct_sched_pkg;

    localparam int BLK_DIM = 8;
    localparam int BLK_PIX = 64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_DRAIN   = 3'd2,
        S_KICK    = 3'd3,
        S_COLLECT = 3'd4,
        S_NEXT    = 3'd5
    } state_e;

    // Index width that stays legal when a dimension holds a single block.
    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    function automatic logic [31:0] pix_addr(input logic [31:0] blk_col,
                                             input logic [31:0] blk_row,
                                             input logic [5:0]  pix_idx,
                                             input logic [31:0] blk_cols);
        logic [31:0] row_s;
        logic [31:0] col_s;
        row_s = {29'd0, pix_idx[5:3]};
        col_s = {29'd0, pix_idx[2:0]};
        return (blk_row * 32'(BLK_DIM) + row_s) * (32'(BLK_DIM) * blk_cols)
               + blk_col * 32'(BLK_DIM) + col_s;
    endfunction

endpackage

// File: rtl/dct_blk_addr_gen.sv
// Block/pixel counters for the frame walk, plus the frame-memory read address
// and the coefficient-memory base address of the current block.
module dct_blk_addr_gen
    import dct_sched_pkg::*;
#(
    parameter int BLK_COLS    = 4,
    parameter int BLK_ROWS    = 4,
    parameter int FR_ADDR_W   = 10,
    parameter int COEF_ADDR_W = 10
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic                          start_i,
    input  logic                          pix_inc_i,
    input  logic                          next_i,
    output logic [idx_w(BLK_COLS)-1:0]    blk_col_o,
    output logic [idx_w(BLK_ROWS)-1:0]    blk_row_o,
    output logic [5:0]                    pix_idx_o,
    output logic                          last_blk_o,
    output logic [FR_ADDR_W-1:0]          fr_addr_o,
    output logic [COEF_ADDR_W-1:0]        coef_base_o
);

    localparam int COL_W = idx_w(BLK_COLS);
    localparam int ROW_W = idx_w(BLK_ROWS);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [5:0]       pix_q, pix_d;
    logic             last_col_s;
    logic             last_row_s;

    assign last_col_s = (32'(col_q) == 32'(BLK_COLS - 1));
    assign last_row_s = (32'(row_q) == 32'(BLK_ROWS - 1));

    // Next-value logic: frame start clears, block advance walks raster order.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        pix_d = pix_q;
        if (start_i) begin
            col_d = {COL_W{1'b0}};
            row_d = {ROW_W{1'b0}};
            pix_d = 6'd0;
        end else if (next_i) begin
            pix_d = 6'd0;
            if (last_col_s) begin
                col_d = {COL_W{1'b0}};
                if (last_row_s) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1'b1);
                end
            end else begin
                col_d = col_q + COL_W'(1'b1);
            end
        end else if (pix_inc_i) begin
            pix_d = pix_q + 6'd1;
        end else begin
            pix_d = pix_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            col_q <= {COL_W{1'b0}};
            row_q <= {ROW_W{1'b0}};
            pix_q <= 6'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            pix_q <= pix_d;
        end
    end

    assign blk_col_o   = col_q;
    assign blk_row_o   = row_q;
    assign pix_idx_o   = pix_q;
    assign last_blk_o  = last_col_s && last_row_s;
    assign fr_addr_o   = FR_ADDR_W'(pix_addr(32'(col_q), 32'(row_q), pix_q, 32'(BLK_COLS)));
    assign coef_base_o = COEF_ADDR_W'((32'(row_q) * 32'(BLK_COLS) + 32'(col_q)) * 32'(BLK_PIX));

endmodule

// File: rtl/dct_frame_scheduler.sv
// Walks a frame block by block: loads 64 pixels into the DCT block RAM, kicks
// the engine, then stores its 64 coefficients at linear addresses.
module dct_frame_scheduler
    import dct_sched_pkg::*;
#(
    parameter int BLK_COLS    = 4,
    parameter int BLK_ROWS    = 4,
    parameter int FR_ADDR_W   = 10,
    parameter int COEF_W      = 16,
    parameter int COEF_ADDR_W = 10
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        frame_start,
    output logic                        frame_busy,
    output logic                        frame_done,
    output logic                        fr_rd_en,
    output logic [FR_ADDR_W-1:0]        fr_addr,
    input  logic [7:0]                  fr_data,
    output logic                        blk_wr_en,
    output logic [5:0]                  blk_addr,
    output logic [7:0]                  blk_data,
    output logic                        dct_start,
    input  logic                        dct_ready,
    input  logic [COEF_W-1:0]           dct_coef,
    output logic                        coef_wr_en,
    output logic [COEF_ADDR_W-1:0]      coef_addr,
    output logic [COEF_W-1:0]           coef_data,
    output logic [idx_w(BLK_COLS)-1:0]  blk_col,
    output logic [idx_w(BLK_ROWS)-1:0]  blk_row
);

    state_e           state_q, state_d;
    logic [5:0]       coef_cnt_q, coef_cnt_d;
    logic             frame_busy_q, frame_busy_d;
    logic             frame_done_q, frame_done_d;
    logic             fr_rd_en_q, fr_rd_en_d;
    logic             blk_wr_en_q, blk_wr_en_d;
    logic [5:0]       blk_addr_q, blk_addr_d;
    logic             dct_start_q, dct_start_d;

    logic             ag_start_s, ag_pix_inc_s, ag_next_s, last_blk_s;
    logic [5:0]       pix_idx_s;
    logic [FR_ADDR_W-1:0]   fr_addr_s;
    logic [COEF_ADDR_W-1:0] coef_base_s;
    logic             coef_wr_en_s;

    dct_blk_addr_gen #(
        .BLK_COLS    (BLK_COLS),
        .BLK_ROWS    (BLK_ROWS),
        .FR_ADDR_W   (FR_ADDR_W),
        .COEF_ADDR_W (COEF_ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst_in      (rst_in),
        .start_i     (ag_start_s),
        .pix_inc_i   (ag_pix_inc_s),
        .next_i      (ag_next_s),
        .blk_col_o   (blk_col),
        .blk_row_o   (blk_row),
        .pix_idx_o   (pix_idx_s),
        .last_blk_o  (last_blk_s),
        .fr_addr_o   (fr_addr_s),
        .coef_base_o (coef_base_s)
    );

    // FSM next state, counter control and next values of the registered strobes.
    always_comb begin
        state_d      = state_q;
        coef_cnt_d   = coef_cnt_q;
        ag_start_s   = 1'b0;
        ag_pix_inc_s = 1'b0;
        ag_next_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_LOAD;
                    ag_start_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                ag_pix_inc_s = 1'b1;
                if (pix_idx_s == 6'd63) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: state_d = S_KICK;
            S_KICK: begin
                coef_cnt_d = 6'd0;
                state_d    = S_COLLECT;
            end
            S_COLLECT: begin
                if (dct_ready) begin
                    coef_cnt_d = coef_cnt_q + 6'd1;
                    if (coef_cnt_q == 6'd63) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_NEXT: begin
                ag_next_s = 1'b1;
                if (last_blk_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Block RAM write trails each read by one cycle, when fr_data arrives.
        frame_busy_d = (state_d != S_IDLE);
        frame_done_d = (state_q == S_NEXT) && last_blk_s;
        fr_rd_en_d   = (state_d == S_LOAD);
        blk_wr_en_d  = (state_q == S_LOAD);
        blk_addr_d   = (state_q == S_LOAD) ? pix_idx_s : 6'd0;
        dct_start_d  = (state_d == S_KICK);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            coef_cnt_q   <= 6'd0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            fr_rd_en_q   <= 1'b0;
            blk_wr_en_q  <= 1'b0;
            blk_addr_q   <= 6'd0;
            dct_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            coef_cnt_q   <= coef_cnt_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            fr_rd_en_q   <= fr_rd_en_d;
            blk_wr_en_q  <= blk_wr_en_d;
            blk_addr_q   <= blk_addr_d;
            dct_start_q  <= dct_start_d;
        end
    end

    assign coef_wr_en_s = (state_q == S_COLLECT) && dct_ready;

    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;
    assign fr_rd_en   = fr_rd_en_q;
    assign fr_addr    = fr_rd_en_q ? fr_addr_s : {FR_ADDR_W{1'b0}};
    assign blk_wr_en  = blk_wr_en_q;
    assign blk_addr   = blk_addr_q;
    assign blk_data   = blk_wr_en_q ? fr_data : 8'd0;
    assign dct_start  = dct_start_q;
    assign coef_wr_en = coef_wr_en_s;
    assign coef_addr  = coef_wr_en_s ? (coef_base_s + COEF_ADDR_W'(coef_cnt_q)) : {COEF_ADDR_W{1'b0}};
    assign coef_data  = coef_wr_en_s ? dct_coef : {COEF_W{1'b0}};

endmodule

// File: tb/tb_dct_frame_scheduler.sv
// Scoreboard bench for dct_frame_scheduler on a 2x2-block frame with a
// frame-memory model and a DCT engine model that emits gapped ready pulses.
module tb_dct_frame_scheduler;

    localparam int BC = 2;
    localparam int BR = 2;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        frame_start;
    logic        frame_busy, frame_done, fr_rd_en;
    logic [9:0]  fr_addr;
    logic [7:0]  fr_data;
    logic        blk_wr_en;
    logic [5:0]  blk_addr;
    logic [7:0]  blk_data;
    logic        dct_start, dct_ready;
    logic [15:0] dct_coef;
    logic        coef_wr_en;
    logic [9:0]  coef_addr;
    logic [15:0] coef_data;
    logic [0:0]  blk_col, blk_row;

    dct_frame_scheduler #(
        .BLK_COLS(BC), .BLK_ROWS(BR), .FR_ADDR_W(10), .COEF_W(16), .COEF_ADDR_W(10)
    ) dut (
        .clk(clk), .rst_in(rst_in), .frame_start(frame_start),
        .frame_busy(frame_busy), .frame_done(frame_done),
        .fr_rd_en(fr_rd_en), .fr_addr(fr_addr), .fr_data(fr_data),
        .blk_wr_en(blk_wr_en), .blk_addr(blk_addr), .blk_data(blk_data),
        .dct_start(dct_start), .dct_ready(dct_ready), .dct_coef(dct_coef),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
        .blk_col(blk_col), .blk_row(blk_row)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int          cyc;
    } exp_t;

    exp_t        fr_q[$], blk_q[$], coef_q[$];
    int          start_q[$];
    int unsigned fr_log[$], coef_log[$];
    int          n_chk = 0, n_fail = 0, n_done = 0, n_starts = 0;
    int          eng_seq = 0, stray_pend = 0, stray_done = 0;
    bit          abort = 1'b0;
    int          gaps[8] = '{0, 1, 0, 3, 5, 0, 2, 4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic all_zero();
        logic [72:0] z;
        z = {frame_busy, frame_done, fr_rd_en, fr_addr, blk_wr_en, blk_addr, blk_data,
             dct_start, coef_wr_en, coef_addr, coef_data, blk_col, blk_row};
        return (z === 73'd0);
    endfunction

    // Expected traffic for a whole frame; start_cyc is the cycle of the first read.
    task automatic push_frame(input int start_cyc);
        int base, bc, br;
        int unsigned a;
        base = eng_seq;
        for (int b = 0; b < BC * BR; b++) begin
            bc = b % BC;
            br = b / BC;
            for (int p = 0; p < 64; p++) begin
                a = dct_sched_pkg::pix_addr(32'(bc), 32'(br), 6'(p), 32'(BC));
                fr_q.push_back('{a, 0, (b == 0) ? start_cyc + p : -1});
                blk_q.push_back('{p, a & 32'hFF, (b == 0) ? start_cyc + 1 + p : -1});
                coef_q.push_back('{b * 64 + p, 32'(16'((base + b) * 64 + p) ^ 16'hA5A5), -1});
            end
        end
        start_q.push_back(start_cyc + 65);
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        push_frame(cyc + 1);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic pulse_frame_start();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (n_done == 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("frame_done_seen", (n_done > 0) ? 32'd1 : 32'd0, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_queues_empty();
        check("fr_q_empty", fr_q.size(), 0);
        check("blk_q_empty", blk_q.size(), 0);
        check("coef_q_empty", coef_q.size(), 0);
        check("start_q_empty", start_q.size(), 0);
    endtask

    // Frame memory: data = addr[7:0], valid one cycle after the read strobe.
    initial begin : frame_mem
        logic       pv;
        logic [9:0] pa;
        fr_data = 8'h00;
        forever begin
            @(negedge clk);
            pv = fr_rd_en;
            pa = fr_addr;
            @(posedge clk); #1;
            fr_data = (pv === 1'b1) ? pa[7:0] : 8'h00;
        end
    end

    // DCT engine model: 64 gapped ready pulses per start, plus stray pulses on request.
    initial begin : engine
        int my_seq;
        dct_ready = 1'b0;
        dct_coef  = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (stray_done != stray_pend) begin
                dct_ready = 1'b1;
                dct_coef  = 16'hDEAD;
                stray_done++;
                @(posedge clk); #1;
                dct_ready = 1'b0;
                dct_coef  = 16'h0000;
            end else if (dct_start === 1'b1 && !abort) begin
                my_seq = eng_seq;
                eng_seq++;
                @(posedge clk); #1;
                for (int i = 0; i < 64; i++) begin
                    if (abort) break;
                    dct_ready = 1'b1;
                    dct_coef  = 16'(my_seq * 64 + i) ^ 16'hA5A5;
                    @(posedge clk); #1;
                    dct_ready = 1'b0;
                    dct_coef  = 16'h0000;
                    for (int g = 0; g < gaps[i % 8] && !abort; g++) begin
                        @(posedge clk); #1;
                    end
                end
                dct_ready = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transaction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_in === 1'b1) begin
            if (fr_rd_en) begin
                if (fr_q.size() == 0) begin
                    check("fr_rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = fr_q.pop_front();
                    check("fr_addr", 32'(fr_addr), e.addr);
                    if (e.cyc >= 0) check("fr_rd_cycle", cyc, e.cyc);
                end
                check("busy_in_load", 32'(frame_busy), 32'd1);
                fr_log.push_back(32'(fr_addr));
            end
            if (blk_wr_en) begin
                if (blk_q.size() == 0) begin
                    check("blk_wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = blk_q.pop_front();
                    check("blk_addr", 32'(blk_addr), e.addr);
                    check("blk_data", 32'(blk_data), e.data);
                    if (e.cyc >= 0) check("blk_wr_cycle", cyc, e.cyc);
                end
            end
            if (coef_wr_en) begin
                if (coef_q.size() == 0) begin
                    check("coef_wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = coef_q.pop_front();
                    check("coef_addr", 32'(coef_addr), e.addr);
                    check("coef_data", 32'(coef_data), e.data);
                end
                coef_log.push_back(32'(coef_addr));
            end
            if (dct_start) begin
                n_starts++;
                if (start_q.size() > 0) check("dct_start_cycle", cyc, start_q.pop_front());
            end
            if (frame_done) begin
                n_done++;
                check("busy_at_done", 32'(frame_busy), 32'd0);
            end
        end
    end

    initial begin : main
        int t, bad;
        rst_in      = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("reset_zero", 32'(all_zero()), 32'd1);
        @(negedge clk);
        rst_in = 1'b1;

        // Idle after reset, with one stray ready pulse that must not write.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 40) stray_pend++;
            check("idle_zero", 32'(all_zero()), 32'd1);
        end

        // Frame 1: stray ready in LOAD, frame_start mid-LOAD and mid-COLLECT.
        start_frame();
        repeat (10) @(posedge clk); #1;
        stray_pend++;
        repeat (8) @(posedge clk);
        pulse_frame_start();
        repeat (130) @(posedge clk);
        pulse_frame_start();
        wait_done(4000);
        check("f1_done_count", n_done, 1);
        check("f1_start_count", n_starts, 4);
        check_queues_empty();
        check("f1_fr_reads", fr_log.size(), 256);
        check("f1_coef_writes", coef_log.size(), 256);
        check("fr_addr_b1_r3c5", fr_log[93], 61);
        check("fr_addr_b2_first", fr_log[128], 128);
        check("coef_addr_b3_first", coef_log[192], 192);
        check("coef_addr_b3_last", coef_log[255], 255);
        bad = 0;
        for (int i = 0; i < coef_log.size(); i++) if (coef_log[i] != i) bad++;
        check("coef_contiguous", bad, 0);
        check("idle_after_frame", 32'(frame_busy), 32'd0);

        // Frame 2: reset during COLLECT of block 1.
        n_done = 0; n_starts = 0;
        fr_log.delete(); coef_log.delete();
        start_frame();
        t = 0;
        while (coef_log.size() < 74 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("reach_collect_b1", (coef_log.size() >= 74) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #3;
        rst_in = 1'b0;
        abort  = 1'b1;
        #1;
        check("rst_mid_zero", 32'(all_zero()), 32'd1);
        fr_q.delete(); blk_q.delete(); coef_q.delete(); start_q.delete();
        repeat (8) @(negedge clk);
        check("rst_hold_zero", 32'(all_zero()), 32'd1);
        check("no_done_aborted", n_done, 0);
        abort  = 1'b0;
        rst_in = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", 32'(all_zero()), 32'd1);

        // Frame 3: restart from block 0.
        n_starts = 0;
        fr_log.delete(); coef_log.delete();
        start_frame();
        wait_done(4000);
        check("f3_done_count", n_done, 1);
        check("f3_start_count", n_starts, 4);
        check_queues_empty();
        check("f3_fr_reads", fr_log.size(), 256);
        check("restart_fr_addr0", fr_log[0], 0);
        check("restart_coef_addr0", coef_log[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
